pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//  Second-generation hazard unit for the 5-stage MIPS pipeline. It sits beside the ID/EX register.
//  It detects load-use hazards with a configurable bubble count, and stalls mfhi/mflo while the
//  multi-cycle mult/div unit is busy. It also flushes IF/ID on a taken branch.
//  Outputs drive PC/IF-ID hold (stall), ID/EX NOP insertion (bubble) and IF/ID squash (flush).
// PARAMETERS
//  LOAD_BUBBLES    1  bubbles inserted per load-use hazard (1..7); 1 = classic single-cycle MEM
//  MULDIV_LATENCY  4  cycles the mult/div unit stays busy after issue from EX (1..15)
//  CNT_W           4  width of the internal down-counters; must hold max(LOAD_BUBBLES, MULDIV_LATENCY)
// PORTS
//  Clk             in   1   pipeline clock, all state updates on rising edge
//  Rst             in   1   synchronous, active-high reset
//  ID_instruction  in   32  instruction currently in IF/ID
//  EX_instruction  in   32  instruction currently in ID/EX
//  EX_RegWrite     in   1   EX-stage instruction writes the register file
//  BranchTaken     in   1   branch/jump in EX resolved taken this cycle
//  stall           out  1   hold PC and IF/ID
//  bubble          out  1   load NOP into ID/EX at next edge
//  flush           out  1   squash IF/ID contents at next edge
//  md_busy         out  1   mult/div unit busy, for observability
// BEHAVIOUR
//  Decode:
//   - Loads are opcodes 100011, 100000, 100001, 100100, 100101; the load destination is EX rt [20:16].
//   - The ID instruction reads rs [25:21] always.
//   - The ID instruction also reads rt [20:16] only for R-type (000000), stores (101011/101000/101001)
//     and beq/bne (000100/000101).
//   - Register $0 never causes a hazard.
//  Load-use:
//   - A hazard exists when EX_RegWrite is high, EX is a load, and the load rt is nonzero and equals
//     a register that ID reads.
//   - Detection is combinational from state LD_IDLE: stall=1 and bubble=1 in the same cycle.
//   - If LOAD_BUBBLES>1, the FSM moves to LD_WAIT with ld_cnt=LOAD_BUBBLES-1.
//   - In LD_WAIT, stall=1 and bubble=1 regardless of inputs; ld_cnt decrements each cycle.
//   - When ld_cnt reaches 0 at the edge, the FSM returns to LD_IDLE. Total bubbles = LOAD_BUBBLES exactly.
//   - Two back-to-back independent loads do not stall (rs/rt mismatch); this follows from the decode above.
//  Mult/div:
//   - Issue is EX opcode 000000 with funct 011000..011011.
//   - Issue loads md_cnt=MULDIV_LATENCY at the edge.
//   - md_busy = (md_cnt!=0). md_cnt decrements while nonzero.
//   - A new issue while busy reloads md_cnt.
//   - ID mfhi/mflo (opcode 0, funct 010000/010010) while md_busy: stall=1, bubble=1.
//   - ID mfhi/mflo with EX mult/div in the same cycle: also stall=1, bubble=1.
//  Branch:
//   - BranchTaken=1 gives flush=1 and bubble=1 for that cycle.
//   - stall is forced 0 so the PC takes the target.
//   - The FSM returns to LD_IDLE and ld_cnt clears.
//   - md_cnt is unaffected because the mult/div op already issued.
//  Priority: Rst > BranchTaken > LD_WAIT > load-use detect > md stall.
//  Reset:
//   - While Rst=1, stall=bubble=flush=md_busy=0 (outputs gated).
//   - At the edge, the FSM goes to LD_IDLE and ld_cnt=md_cnt=0.
//   - Reset mid-stall aborts the stall; the first post-reset cycle re-evaluates from LD_IDLE.
//  Counter arithmetic: unsigned CNT_W bits, no wrap. Decrement only when nonzero.
//  Latency: detection to output is 0 cycles (combinational). Counter effects appear one edge later.
// STRUCTURE
//  - Package hazard_pkg holds the opcode/funct localparams (OP_RTYPE, OP_LW.., FN_MULT.., FN_MFHI,
//    FN_MFLO) and the FSM state encoding (LD_IDLE, LD_WAIT).
//  - Sub-module hazard_decode is combinational and instantiated twice, once per stage. It outputs
//    is_load, reads_rs, reads_rt, is_muldiv, is_mfhilo, rs, rt.
//  - The top level holds the LD FSM, both counters and the priority mux.
// TESTING
//  1. LOAD_BUBBLES=1: EX lw $8,0($1) with RegWrite; ID add $9,$8,$2
//     -> stall=bubble=1 for exactly 1 cycle, then 0.
//  2. LOAD_BUBBLES=3: EX lw $8; ID sw $8,4($3) (rt use)
//     -> stall=bubble=1 for 3 consecutive cycles, then 0. Repeat with ID addi $8,$0,1 (rt is dest)
//     -> no stall.
//  3. EX lw $0,0($1); ID add $9,$0,$0 -> no stall. EX lw $8; ID lw $9,0($4) -> no stall.
//  4. MULDIV_LATENCY=4: EX mult $2,$3. ID mflo $5 arrives 2 cycles later
//     -> stall for 2 cycles; md_busy falls 4 cycles after issue.
//  5. LOAD_BUBBLES=3: mid LD_WAIT (2nd bubble) assert BranchTaken=1
//     -> flush=1, stall=0 that cycle; next cycle stall=0 (FSM idle).
//  6. Assert Rst during LD_WAIT and with md_cnt=3
//     -> outputs 0 while Rst=1; after release md_busy=0 and no residual stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
//  Shared opcode/funct encodings and the load-use FSM state type for the
//  pipeline hazard unit and its decode helper.
package hazard_pkg;

  // Primary opcodes the hazard unit cares about
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // R-type funct codes for the mult/div unit and HI/LO moves
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Load-use FSM: idle/detect, or burning extra bubbles for slow loads
  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_t;

endpackage

// File: rtl/hazard_decode.sv
// hazard_decode
//  Combinational decode of one pipeline-stage instruction into the few
//  facts the hazard unit needs. Instantiated once for ID and once for EX.
// Ports:
//  instruction  in   32  instruction word of the stage
//  is_load      out  1   instruction is a load (destination in rt)
//  reads_rs     out  1   instruction reads rs
//  reads_rt     out  1   instruction reads rt (R-type, stores, beq/bne)
//  is_muldiv    out  1   R-type mult/multu/div/divu
//  is_mfhilo    out  1   R-type mfhi/mflo
//  rs           out  5   rs field
//  rt           out  5   rt field
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        is_load,
  output logic        reads_rs,
  output logic        reads_rt,
  output logic        is_muldiv,
  output logic        is_mfhilo,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instruction[31:26];
  assign funct       = instruction[5:0];
  assign rs          = instruction[25:21];
  assign rt          = instruction[20:16];
  // rd/shamt/immediate upper bits play no part in hazard decisions
  assign unused_bits = ^instruction[15:6];

  // Every format in this ISA subset uses rs as a source (or base), so rs is
  // treated as read unconditionally; rt is a source only for the listed classes
  // and is a destination for I-type ALU ops and loads.
  always_comb begin
    is_load   = (opcode == OP_LW)  || (opcode == OP_LB)  || (opcode == OP_LH) ||
                (opcode == OP_LBU) || (opcode == OP_LHU);
    reads_rs  = 1'b1;
    reads_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_SB) ||
                (opcode == OP_SH)    || (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_muldiv = (opcode == OP_RTYPE) &&
                ((funct == FN_MULT) || (funct == FN_MULTU) ||
                 (funct == FN_DIV)  || (funct == FN_DIVU));
    is_mfhilo = (opcode == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//  Hazard unit beside the ID/EX register of the 5-stage MIPS pipeline.
//  Detects load-use hazards (LOAD_BUBBLES bubbles each), stalls mfhi/mflo
//  while the multi-cycle mult/div unit is busy, and flushes IF/ID on a
//  taken branch.
// Ports:
//  Clk             in   1   pipeline clock
//  Rst             in   1   synchronous active-high reset
//  ID_instruction  in   32  instruction in IF/ID
//  EX_instruction  in   32  instruction in ID/EX
//  EX_RegWrite     in   1   EX instruction writes the register file
//  BranchTaken     in   1   branch/jump in EX resolved taken
//  stall           out  1   hold PC and IF/ID
//  bubble          out  1   load NOP into ID/EX at next edge
//  flush           out  1   squash IF/ID at next edge
//  md_busy         out  1   mult/div unit busy
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES   = 1,
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] ID_instruction,
  input  logic [31:0] EX_instruction,
  input  logic        EX_RegWrite,
  input  logic        BranchTaken,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        md_busy
);

  logic             id_is_load, id_reads_rs, id_reads_rt, id_is_muldiv, id_is_mfhilo;
  logic [4:0]       id_rs, id_rt;
  logic             ex_is_load, ex_reads_rs, ex_reads_rt, ex_is_muldiv, ex_is_mfhilo;
  logic [4:0]       ex_rs, ex_rt;
  logic             unused_decode;

  ld_state_t        state, state_next;
  logic [CNT_W-1:0] ld_cnt, ld_cnt_next;
  logic [CNT_W-1:0] md_cnt;
  logic             ld_hazard;
  logic             md_hazard;
  logic             md_active;

  hazard_decode u_id_decode (
    .instruction (ID_instruction),
    .is_load     (id_is_load),
    .reads_rs    (id_reads_rs),
    .reads_rt    (id_reads_rt),
    .is_muldiv   (id_is_muldiv),
    .is_mfhilo   (id_is_mfhilo),
    .rs          (id_rs),
    .rt          (id_rt)
  );

  hazard_decode u_ex_decode (
    .instruction (EX_instruction),
    .is_load     (ex_is_load),
    .reads_rs    (ex_reads_rs),
    .reads_rt    (ex_reads_rt),
    .is_muldiv   (ex_is_muldiv),
    .is_mfhilo   (ex_is_mfhilo),
    .rs          (ex_rs),
    .rt          (ex_rt)
  );

  // Decode facts that are irrelevant for the stage they describe
  assign unused_decode = ^{id_is_load, id_is_muldiv, ex_reads_rs, ex_reads_rt,
                           ex_is_mfhilo, ex_rs};

  assign md_active = (md_cnt != '0);

  // Load-use: $0 is hardwired, so a load into $0 never creates a dependency.
  // mfhi/mflo must also wait when the mult/div is only now issuing from EX,
  // because md_cnt is not loaded until the coming edge.
  always_comb begin
    ld_hazard = EX_RegWrite && ex_is_load && (ex_rt != 5'd0) &&
                ((id_reads_rs && (id_rs == ex_rt)) ||
                 (id_reads_rt && (id_rt == ex_rt)));
    md_hazard = id_is_mfhilo && (md_active || ex_is_muldiv);
  end

  // Load-use FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= LD_IDLE;
      ld_cnt <= '0;
    end else begin
      state  <= state_next;
      ld_cnt <= ld_cnt_next;
    end
  end

  // Next state: the detect cycle supplies the first bubble, LD_WAIT supplies
  // the remaining LOAD_BUBBLES-1, leaving when the counter hits zero.
  // A taken branch kills the dependent instruction, so the wait is dropped.
  always_comb begin
    state_next  = state;
    ld_cnt_next = ld_cnt;
    if (BranchTaken) begin
      state_next  = LD_IDLE;
      ld_cnt_next = '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (ld_hazard && (LOAD_BUBBLES > 1)) begin
            state_next  = LD_WAIT;
            ld_cnt_next = CNT_W'(LOAD_BUBBLES - 1);
          end
        end
        LD_WAIT: begin
          if (ld_cnt <= CNT_W'(1)) begin
            state_next  = LD_IDLE;
            ld_cnt_next = '0;
          end else begin
            ld_cnt_next = ld_cnt - CNT_W'(1);
          end
        end
        default: begin
          state_next  = LD_IDLE;
          ld_cnt_next = '0;
        end
      endcase
    end
  end

  // Output priority: reset, branch, pending load wait, load-use, mult/div.
  // A branch must not stall, otherwise the PC could not take the target.
  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    md_busy = 1'b0;
    if (!Rst) begin
      md_busy = md_active;
      if (BranchTaken) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (state == LD_WAIT) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else if (ld_hazard || md_hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // Mult/div busy counter: an issue from EX (re)loads the full latency, and
  // branches leave it alone because the operation has already been issued.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      md_cnt <= '0;
    end else if (ex_is_muldiv) begin
      md_cnt <= CNT_W'(MULDIV_LATENCY);
    end else if (md_active) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
//  Drives two hazard units (LOAD_BUBBLES=1 and =3, both MULDIV_LATENCY=4)
//  from shared inputs. Each stimulus cycle pushes the hand-computed outputs
//  of both units into a queue; a monitor on the falling edge pops and compares.
//  Expected nibble layout: {stall, bubble, flush, md_busy}.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic [31:0] ex_instr;
  logic        ex_reg_write;
  logic        branch_taken;

  logic stall_1, bubble_1, flush_1, md_busy_1;
  logic stall_3, bubble_3, flush_3, md_busy_3;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.LOAD_BUBBLES(1), .MULDIV_LATENCY(4), .CNT_W(4)) dut_lb1 (
    .Clk            (clk),
    .Rst            (rst),
    .ID_instruction (id_instr),
    .EX_instruction (ex_instr),
    .EX_RegWrite    (ex_reg_write),
    .BranchTaken    (branch_taken),
    .stall          (stall_1),
    .bubble         (bubble_1),
    .flush          (flush_1),
    .md_busy        (md_busy_1)
  );

  pipeline_hazard_unit #(.LOAD_BUBBLES(3), .MULDIV_LATENCY(4), .CNT_W(4)) dut_lb3 (
    .Clk            (clk),
    .Rst            (rst),
    .ID_instruction (id_instr),
    .EX_instruction (ex_instr),
    .EX_RegWrite    (ex_reg_write),
    .BranchTaken    (branch_taken),
    .stall          (stall_3),
    .bubble         (bubble_3),
    .flush          (flush_3),
    .md_busy        (md_busy_3)
  );

  typedef struct {
    logic [3:0] lb1;
    logic [3:0] lb3;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected output patterns {stall, bubble, flush, md_busy}
  localparam logic [3:0] QUIET = 4'b0000;
  localparam logic [3:0] STL   = 4'b1100;
  localparam logic [3:0] FLS   = 4'b0110;
  localparam logic [3:0] BSY   = 4'b0001;
  localparam logic [3:0] STB   = 4'b1101;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] nop, lw8, add9_8_2, sw8_3, addi8, lw0, add9_0_0, lw9_4;
  logic [31:0] mult23, mflo5, mfhi5, sw5_8;

  // Drive one cycle of inputs just after the rising edge and queue what both
  // units must show during that cycle.
  task automatic applyStimulus(input string name, input logic [31:0] id, input logic [31:0] ex,
                               input logic rw, input logic br, input logic rst_v,
                               input logic [3:0] exp_lb1, input logic [3:0] exp_lb3);
    exp_t e;
    @(posedge clk);
    #1;
    id_instr     = id;
    ex_instr     = ex;
    ex_reg_write = rw;
    branch_taken = br;
    rst          = rst_v;
    e.lb1  = exp_lb1;
    e.lb3  = exp_lb3;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input string unit,
                             input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s %s: got stall/bubble/flush/md_busy=%b, want %b",
               name, unit, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so one sample per queued cycle,
  // taken at the falling edge well away from the updating edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.name, "lb1", {stall_1, bubble_1, flush_1, md_busy_1}, e.lb1);
      checkOutput(e.name, "lb3", {stall_3, bubble_3, flush_3, md_busy_3}, e.lb3);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nop      = 32'd0;
    lw8      = i_type(6'b100011, 5'd1, 5'd8, 16'd0);
    add9_8_2 = r_type(5'd8, 5'd2, 5'd9, 6'b100000);
    sw8_3    = i_type(6'b101011, 5'd3, 5'd8, 16'd4);
    addi8    = i_type(6'b001000, 5'd0, 5'd8, 16'd1);
    lw0      = i_type(6'b100011, 5'd1, 5'd0, 16'd0);
    add9_0_0 = r_type(5'd0, 5'd0, 5'd9, 6'b100000);
    lw9_4    = i_type(6'b100011, 5'd4, 5'd9, 16'd0);
    mult23   = r_type(5'd2, 5'd3, 5'd0, 6'b011000);
    mflo5    = r_type(5'd0, 5'd0, 5'd5, 6'b010010);
    mfhi5    = r_type(5'd0, 5'd0, 5'd5, 6'b010000);
    sw5_8    = i_type(6'b101011, 5'd8, 5'd5, 16'd0);

    rst          = 1'b1;
    id_instr     = add9_8_2;
    ex_instr     = lw8;
    ex_reg_write = 1'b1;
    branch_taken = 1'b0;

    // Reset gates outputs even with a live hazard on the inputs
    applyStimulus("rst0", add9_8_2, lw8, 1'b1, 1'b0, 1'b1, QUIET, QUIET);
    applyStimulus("rst1", add9_8_2, lw8, 1'b1, 1'b0, 1'b1, QUIET, QUIET);

    // lw $8 then add $9,$8,$2 (rs use); EX becomes a NOP after the bubble
    applyStimulus("ld_rs_0", add9_8_2, lw8, 1'b1, 1'b0, 1'b0, STL,   STL);
    applyStimulus("ld_rs_1", add9_8_2, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_rs_2", add9_8_2, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_rs_3", add9_8_2, nop, 1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // lw $8 then sw $8,4($3) (rt use)
    applyStimulus("ld_rt_0", sw8_3, lw8, 1'b1, 1'b0, 1'b0, STL,   STL);
    applyStimulus("ld_rt_1", sw8_3, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_rt_2", sw8_3, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_rt_3", sw8_3, nop, 1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // No-hazard cases: rt is a destination, no RegWrite, $0, independent loads
    applyStimulus("addi_dst", addi8,    lw8,   1'b1, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("no_rw",    add9_8_2, lw8,   1'b0, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("reg0",     add9_0_0, lw0,   1'b1, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("ld_ld",    lw9_4,    lw8,   1'b1, 1'b0, 1'b0, QUIET, QUIET);

    // mult issue, mflo enters ID while md_cnt=2 -> 2 stall cycles,
    // md_busy high for 4 cycles after the issue cycle
    applyStimulus("md_iss", nop,   mult23, 1'b0, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("md_b4",  nop,   nop,    1'b0, 1'b0, 1'b0, BSY,   BSY);
    applyStimulus("md_b3",  nop,   nop,    1'b0, 1'b0, 1'b0, BSY,   BSY);
    applyStimulus("md_b2",  mflo5, nop,    1'b0, 1'b0, 1'b0, STB,   STB);
    applyStimulus("md_b1",  mflo5, nop,    1'b0, 1'b0, 1'b0, STB,   STB);
    applyStimulus("md_b0",  mflo5, nop,    1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // mfhi in ID alongside mult in EX, then a reissue while busy reloads
    applyStimulus("md_same", mfhi5, mult23, 1'b0, 1'b0, 1'b0, STL, STL);
    applyStimulus("md_r4",   nop,   nop,    1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_rel",  nop,   mult23, 1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_n4",   nop,   nop,    1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_n3",   nop,   nop,    1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_n2",   nop,   nop,    1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_n1",   nop,   nop,    1'b0, 1'b0, 1'b0, BSY, BSY);
    applyStimulus("md_n0",   nop,   nop,    1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // Branch taken on the 2nd load bubble: flush wins, FSM returns idle
    applyStimulus("br_0", add9_8_2, lw8, 1'b1, 1'b0, 1'b0, STL,   STL);
    applyStimulus("br_1", add9_8_2, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("br_2", add9_8_2, nop, 1'b0, 1'b1, 1'b0, FLS,   FLS);
    applyStimulus("br_3", nop,      nop, 1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // Reset while LD_WAIT and md_cnt=3, then no residual stall or busy
    applyStimulus("rs_iss",  nop,      mult23, 1'b0, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("rs_ld",   add9_8_2, lw8,    1'b1, 1'b0, 1'b0, STB,   STB);
    applyStimulus("rs_on",   add9_8_2, nop,    1'b0, 1'b0, 1'b1, QUIET, QUIET);
    applyStimulus("rs_off",  add9_8_2, nop,    1'b0, 1'b0, 1'b0, QUIET, QUIET);
    applyStimulus("rs_mflo", mflo5,    nop,    1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // Store base register (rs) depending on the load
    applyStimulus("ld_base_0", sw5_8, lw8, 1'b1, 1'b0, 1'b0, STL,   STL);
    applyStimulus("ld_base_1", sw5_8, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_base_2", sw5_8, nop, 1'b0, 1'b0, 1'b0, QUIET, STL);
    applyStimulus("ld_base_3", sw5_8, nop, 1'b0, 1'b0, 1'b0, QUIET, QUIET);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
